// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB configuration slave.
// FSM states, register offsets, CTRL field positions.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;

    localparam int CTRL_WAIT_LSB  = 0;
    localparam int CTRL_WAIT_W    = 4;
    localparam int CTRL_ERREN_BIT = 8;
    localparam int CTRL_CLR_BIT   = 31;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// Byte-enable memory array with registered read port.
// Whole array clears on reset.
module apb_mem_bank #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 6
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    we,
    input  logic                    re,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Lane-masked write and synchronous read; reset zeroes everything.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                    if (be[k]) begin
                        mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/apb_cfg_slave.sv
// APB4 slave: memory window plus CTRL/STATUS registers,
// with programmable wait states and error reporting.
module apb_cfg_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 64,
    parameter int DEFAULT_WAIT = 3
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IW  = ADDR_WIDTH - 1;
    localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CLR = (DATA_WIDTH >= 32) ? CTRL_CLR_BIT : DATA_WIDTH - 1;

    state_t                state;
    logic [3:0]            cnt;
    logic [3:0]            ctrl_wait;
    logic                  ctrl_err_en;
    logic [15:0]           err_count;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rd_sel_mem;

    logic [IW-1:0]         idx;
    logic                  is_reg;
    logic                  mem_oob;
    logic                  reg_bad;
    logic                  acc_err;
    logic                  done_now;
    logic                  mem_we;
    logic                  mem_re;
    logic [3:0]            wait_new;
    logic                  en_new;
    logic                  clr_req;
    logic [DATA_WIDTH-1:0] ctrl_rd;
    logic [DATA_WIDTH-1:0] reg_rd_val;

    assign idx      = PADDR[IW-1:0];
    assign is_reg   = PADDR[IW];
    assign mem_oob  = !is_reg && ({1'b0, idx} >= ADDR_WIDTH'(MEM_DEPTH));
    assign reg_bad  = is_reg && ((idx > IW'(REG_STATUS)) ||
                      ((idx == IW'(REG_STATUS)) && PWRITE));
    assign acc_err  = mem_oob || reg_bad;
    assign done_now = (state == ST_BUSY) && PSEL && (cnt == 4'd0);
    assign mem_we   = done_now && !acc_err && !is_reg && PWRITE;
    assign mem_re   = done_now && !acc_err && !is_reg && !PWRITE;

    assign wait_new = PSTRB[0] ? PWDATA[CTRL_WAIT_LSB +: CTRL_WAIT_W]
                               : ctrl_wait;
    assign clr_req  = PSTRB[CLR/8] & PWDATA[CLR];

    // err_en lives in byte lane 1, which narrow buses do not have.
    if (DATA_WIDTH >= 16) begin : g_en
        assign en_new = PSTRB[1] ? PWDATA[CTRL_ERREN_BIT] : ctrl_err_en;
    end else begin : g_no_en
        assign en_new = ctrl_err_en;
    end

    assign ctrl_rd = (DATA_WIDTH'(ctrl_err_en) << CTRL_ERREN_BIT) |
                     (DATA_WIDTH'(ctrl_wait) << CTRL_WAIT_LSB);
    assign reg_rd_val = (idx == IW'(REG_CTRL)) ? ctrl_rd
                                               : DATA_WIDTH'(err_count);

    // PRDATA is always a registered source; select tracks the last read.
    assign PRDATA = rd_sel_mem ? mem_rdata : reg_rdata;

    apb_mem_bank #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (MAW)
    ) u_mem (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (MAW'(idx)),
        .be      (PSTRB),
        .wdata   (PWDATA),
        .rdata   (mem_rdata)
    );

    // Transfer FSM with wait counter, registers and response flags.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            PREADY      <= 1'b0;
            PSLVERR     <= 1'b0;
            ctrl_wait   <= 4'(DEFAULT_WAIT);
            ctrl_err_en <= 1'b1;
            err_count   <= '0;
            reg_rdata   <= '0;
            rd_sel_mem  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    if (PSEL && PENABLE) begin
                        cnt   <= ctrl_wait;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        PREADY <= 1'b1;
                        state  <= ST_DONE;
                        if (acc_err) begin
                            PSLVERR <= ctrl_err_en;
                            if (ctrl_err_en) begin
                                err_count <= sat_inc(err_count);
                            end
                            if (!PWRITE) begin
                                rd_sel_mem <= 1'b0;
                                reg_rdata  <= '0;
                            end
                        end else if (PWRITE) begin
                            if (is_reg) begin
                                ctrl_wait   <= wait_new;
                                ctrl_err_en <= en_new;
                                if (clr_req) begin
                                    err_count <= '0;
                                end
                            end
                        end else if (is_reg) begin
                            rd_sel_mem <= 1'b0;
                            reg_rdata  <= reg_rd_val;
                        end else begin
                            rd_sel_mem <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cfg_slave.sv
// Directed bench for apb_cfg_slave.
// One task per scenario with inline hand-computed checks.
module tb_apb_cfg_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [3:0]  PSTRB;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_vec = 0;
    int n_err = 0;

    apb_cfg_slave #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (32),
        .MEM_DEPTH    (64),
        .DEFAULT_WAIT (3)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PSTRB   (PSTRB),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Full APB transfer; lat = edges after the access-sampling edge.
    // Returns one cycle after DONE with PSEL still high so calls chain.
    task automatic xfer(input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err,
                        output int lat);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wd;
        PSTRB   = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        lat = 0;
        while (lat < 40) begin
            @(posedge PCLK); #1;
            lat++;
            if (PREADY) break;
        end
        rd  = PRDATA;
        err = PSLVERR;
        n_vec++;
        if (PREADY !== 1'b1) begin
            n_err++;
            $display("FAIL timeout addr=%h: PREADY=%b after %0d cycles, want 1",
                     addr, PREADY, lat);
        end
        @(posedge PCLK); #1;
    endtask

    task automatic idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_reset();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        PADDR = '0; PSTRB = '0; PWDATA = '0;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        n_vec++;
        if (PREADY !== 1'b0) begin
            n_err++; $display("FAIL reset_pready: got %b want 0", PREADY);
        end
        n_vec++;
        if (PSLVERR !== 1'b0) begin
            n_err++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR);
        end
        n_vec++;
        if (PRDATA !== 32'h0) begin
            n_err++; $display("FAIL reset_prdata: got %h want 0", PRDATA);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_read_default();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b0, 8'd5, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL rd_mem5_data: got %h want 0", rd);
        end
        n_vec++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL rd_mem5_err: got %b want 0", err);
        end
        n_vec++;
        if (lat !== 4) begin
            n_err++; $display("FAIL rd_mem5_latency: got %0d want 4", lat);
        end
        n_vec++;
        if (PREADY !== 1'b0) begin
            n_err++; $display("FAIL pready_one_cycle: got %b want 0", PREADY);
        end
        idle();
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 8'd2, 32'hAABBCCDD, 4'b1111, rd, err, lat);
        xfer(1'b1, 8'd2, 32'h11223344, 4'b0101, rd, err, lat);
        n_vec++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL strobe_wr_err: got %b want 0", err);
        end
        xfer(1'b0, 8'd2, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'hAA22CC44) begin
            n_err++; $display("FAIL strobe_merge: got %h want aa22cc44", rd);
        end
        idle();
    endtask

    task automatic test_wait();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 8'h80, 32'h0000_0100, 4'hF, rd, err, lat);
        xfer(1'b0, 8'd2, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++; $display("FAIL wait0_latency: got %0d want 1", lat);
        end
        xfer(1'b0, 8'h80, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0000_0100) begin
            n_err++; $display("FAIL ctrl_rd_wait0: got %h want 00000100", rd);
        end
        xfer(1'b1, 8'h80, 32'h0000_010F, 4'hF, rd, err, lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++; $display("FAIL wait15_write_latency: got %0d want 1", lat);
        end
        xfer(1'b0, 8'd2, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (lat !== 16) begin
            n_err++; $display("FAIL wait15_latency: got %0d want 16", lat);
        end
        xfer(1'b1, 8'h80, 32'h0000_0101, 4'hF, rd, err, lat);
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 8'd100, 32'hDEAD_BEEF, 4'hF, rd, err, lat);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL oob_write_err: got %b want 1", err);
        end
        xfer(1'b0, 8'h81, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'd1) begin
            n_err++; $display("FAIL status_after_oob: got %h want 1", rd);
        end
        xfer(1'b1, 8'h81, 32'h0, 4'hF, rd, err, lat);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL status_write_err: got %b want 1", err);
        end
        xfer(1'b0, 8'h81, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'd2) begin
            n_err++; $display("FAIL status_after_wr: got %h want 2", rd);
        end
        xfer(1'b0, 8'h82, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL bad_offset_rd: got err=%b data=%h want err=1 data=0",
                     err, rd);
        end
        xfer(1'b0, 8'h81, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'd3) begin
            n_err++; $display("FAIL status_after_bad_off: got %h want 3", rd);
        end
        xfer(1'b1, 8'h80, 32'h8000_0101, 4'hF, rd, err, lat);
        xfer(1'b0, 8'h81, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL status_cleared: got %h want 0", rd);
        end
        xfer(1'b0, 8'h80, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0000_0101) begin
            n_err++; $display("FAIL ctrl_clr_bit_reads0: got %h want 00000101", rd);
        end
        xfer(1'b1, 8'h80, 32'h0000_0001, 4'b0011, rd, err, lat);
        xfer(1'b0, 8'h82, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL err_en0_suppress: got %b want 0", err);
        end
        xfer(1'b0, 8'h81, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'd0) begin
            n_err++; $display("FAIL err_en0_no_count: got %h want 0", rd);
        end
        xfer(1'b1, 8'h80, 32'h0000_0100, 4'b0010, rd, err, lat);
        xfer(1'b0, 8'h80, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0000_0101) begin
            n_err++; $display("FAIL ctrl_lane_strobe: got %h want 00000101", rd);
        end
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat; logic seen;
        xfer(1'b1, 8'h80, 32'h0000_0103, 4'hF, rd, err, lat);
        PWRITE = 1'b1; PADDR = 8'd3; PWDATA = 32'h5; PSTRB = 4'hF;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge PCLK); #1;
            if (PREADY) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL abort_pready: got %b want 0", seen);
        end
        xfer(1'b0, 8'd3, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL abort_no_write: got %h want 0", rd);
        end
        xfer(1'b0, 8'h81, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL abort_status: got %h want 0", rd);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 8'd10, 32'h1234_5678, 4'hF, rd, err, lat);
        xfer(1'b0, 8'd10, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h1234_5678 || lat !== 4) begin
            n_err++;
            $display("FAIL b2b_read: got %h lat %0d want 12345678 lat 4",
                     rd, lat);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat;
        xfer(1'b1, 8'h80, 32'h0000_010F, 4'hF, rd, err, lat);
        xfer(1'b0, 8'd10, 32'h0, 4'h0, rd, err, lat);
        PWRITE = 1'b1; PADDR = 8'd4; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b0;
        #1;
        n_vec++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got rdy=%b err=%b data=%h want 0 0 0",
                     PREADY, PSLVERR, PRDATA);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1'b0, 8'h80, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0000_0103 || lat !== 4) begin
            n_err++;
            $display("FAIL ctrl_after_reset: got %h lat %0d want 00000103 lat 4",
                     rd, lat);
        end
        xfer(1'b0, 8'd4, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL mid_reset_no_write: got %h want 0", rd);
        end
        xfer(1'b0, 8'd10, 32'h0, 4'h0, rd, err, lat);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL mem_cleared: got %h want 0", rd);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_read_default();
        test_byte_strobe();
        test_wait();
        test_errors();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
